// File: rtl/btn_int_ctrl.sv
// Button interrupt controller: sync + debounce four buttons, latch presses as pending,
// pick the highest enabled one and hand it to the core through a req/ack/done handshake.
module btn_int_ctrl #(
    parameter logic [15:0] VEC_BASE   = 16'h0f80,
    parameter logic [15:0] VEC_STRIDE = 16'h0020,
    parameter int unsigned DB_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn_in,
    input  logic [3:0]  int_en,
    input  logic        int_ack,
    input  logic        int_done,
    output logic        int_req,
    output logic [1:0]  int_id,
    output logic [15:0] int_vec,
    output logic        in_service,
    output logic [3:0]  pending
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       stable_q, stable_d;
    logic [3:0][15:0] cnt_q, cnt_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       eligible, ack_clr;
    logic [1:0]       win_id;
    logic [15:0]      win_slot, win_vec;

    state_t      state_q;
    logic        int_req_q, in_service_q;
    logic [1:0]  int_id_q;
    logic [15:0] int_vec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // A level change is accepted only after DB_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < 4; k++) begin
            if (sync2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == DB_LAST) begin
                stable_d[k] = sync2_q[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    always_comb begin
        ack_clr = '0;
        if (state_q == REQ && int_ack)
            ack_clr = 4'b0001 << int_id_q;
    end

    // A rising stable edge wins over a same-cycle acknowledge clear.
    assign pending_d = (pending_q & ~ack_clr) | (stable_d & ~stable_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q  <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign eligible = pending_q & int_en;

    always_comb begin
        win_id = 2'd0;
        for (int k = 0; k < 4; k++)
            if (eligible[k]) win_id = 2'(k);
    end

    // (3 - k) for a 2-bit index is its bitwise complement.
    assign win_slot = {14'd0, ~win_id};
    assign win_vec  = VEC_BASE + VEC_STRIDE * win_slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
            int_id_q     <= '0;
            int_vec_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eligible != 4'd0) begin
                        int_id_q  <= win_id;
                        int_vec_q <= win_vec;
                        int_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req_q    <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (int_done) begin
                        in_service_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    int_req_q    <= 1'b0;
                    in_service_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign int_req    = int_req_q;
    assign int_id     = int_id_q;
    assign int_vec    = int_vec_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
endmodule

// File: doc/btn_int_ctrl.md
# btn_int_ctrl

Button interrupt controller for the CPU core. It synchronizes and debounces the four active-high push buttons, latches each press as a pending request, and selects the highest-priority enabled request. It then runs a request/acknowledge/return handshake with the execute stage, so the core sees one clean, non-nesting interrupt at a time with a stable vector. It replaces direct use of raw `buttons_pressed` at the EXE-stage branch mux.

## Interface
Parameters:
- `VEC_BASE`, 16'h0f80, vector of button 3 (highest priority)
- `VEC_STRIDE`, 16'h0020, vector spacing; button k vector = `VEC_BASE + (3-k)*VEC_STRIDE`
- `DB_CYCLES`, 16, consecutive differing samples needed to accept a level change (2..65535)

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  reset, asynchronous, active-high
- `btn_in`  in  4  raw buttons, active high, asynchronous to `clk`
- `int_en`  in  4  per-button arbitration enable
- `int_ack`  in  1  one-cycle pulse: core has taken the vector
- `int_done`  in  1  one-cycle pulse: core executed RET from handler
- `int_req`  out  1  interrupt request to core
- `int_id`  out  2  index of requested/serviced button
- `int_vec`  out  16  handler address for `int_id`
- `in_service`  out  1  handler running
- `pending`  out  4  latched, not-yet-acknowledged presses

## Operation
- Synchronizer: two flops per bit (`sync1`, `sync2`).
- Debounce, per bit:
  - Keep a 16-bit counter and a `stable` level.
  - If `sync2 == stable`, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals `DB_CYCLES-1` and `sync2 != stable`, `stable` takes `sync2` and the counter clears.
- Pending: `pending[k]` sets on the edge where `stable[k]` goes 0→1. It clears on an acknowledge of `k`. If set and clear hit the same edge, set wins. Presses of an already-pending button merge.
- Arbitration: `eligible = pending & int_en`. The winner is the highest eligible index.
- FSM:
  - IDLE: if `eligible != 0`, latch winner into `int_id`/`int_vec` and go to REQ.
  - REQ: `int_req=1`; `int_id`/`int_vec` held. A newly eligible higher-priority press does not change the latched vector. On `int_ack`, clear `pending[int_id]` and go to SERVICE. If `int_en[int_id]` drops while in REQ, the request stays until acked.
  - SERVICE: `in_service=1`, `int_req=0`, `int_id`/`int_vec` held. New presses only set `pending` (no nesting). On `int_done`, go to IDLE.
- Ignored inputs: `int_ack` outside REQ and `int_done` outside SERVICE.
- `int_en` masks arbitration only, never latching.

## Timing
- Reset: all outputs 0 (`int_vec` = 16'h0000), FSM = IDLE, sync/stable/counters/pending = 0. Reset mid-REQ or mid-SERVICE drops the request, returns to IDLE and loses pending presses.
- Press latency: `btn_in` rises and stays high. `sync2` is high after 2 edges. `stable` and `pending` are set after `DB_CYCLES` further edges. `int_req` asserts at the next edge. Total: `DB_CYCLES+3` edges.
- Glitch rejection: a pulse shorter than `DB_CYCLES` cycles at `sync2` sets nothing. Release is debounced the same way; a new press requires release to be accepted first.
- Ack: `int_ack` sampled high in REQ. `int_req` falls, and `in_service` and the pending clear take effect at that edge.
- Back-to-back: `int_done` at edge e returns to IDLE. If another request is eligible, `int_req` reasserts at e+1, so there is a minimum of one IDLE cycle between services.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately, remain 0 while held.
- Single press, `DB_CYCLES`=4, `int_en`=4'hF:
  - `btn_in`=4'b0001 held → `int_req`=1, `int_id`=0, `int_vec`=16'h0fe0, 7 edges after the rise.
  - `int_ack` → `in_service`=1, `pending`=0.
  - `int_done` → IDLE.
- Glitch, `DB_CYCLES`=4: `btn_in[2]` high for 3 cycles → `pending` stays 0, `int_req` stays 0.
- Priority and latching, `DB_CYCLES`=4:
  - Buttons 1 and 3 pressed together → `int_vec`=16'h0f80 (id 3).
  - After ack/done → `int_vec`=16'h0fc0 (id 1); `int_req` reasserts exactly one cycle after `int_done`.
  - A press of button 2 during REQ of id 1 → latched vector unchanged.
- Mask: `int_en`=4'b0111, press button 3 → `pending`=4'b1000, `int_req`=0. Set `int_en`=4'hF → `int_req`=1 next edge, `int_vec`=16'h0f80.
- Protocol violations:
  - Spurious `int_ack` in IDLE and `int_done` in REQ → no state change.
  - Re-press of the serviced button during SERVICE → `pending` bit set, serviced after `int_done`.
